// File: rtl/zx_key_autotyper_if.sv
// Event handshake between a key-event producer (OSD menu, tape auto-loader)
// and the autotyper queue.
//   ev_data  : [2:0] row, [5:3] column, [6] add CAPS SHIFT, [7] add SYMBOL SHIFT
//   ev_valid : producer offers ev_data
//   ev_ready : autotyper can accept an event this cycle
interface zx_key_autotyper_if;
    logic [7:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_data, output ev_valid, input ev_ready);
    modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/zx_key_autotyper.sv
// Timed key-injection sequencer for the ZX keyboard matrix. Queued key events
// are pressed for HOLD_CYCLES clocks, then all injected keys are released for
// GAP_CYCLES clocks. The physical keyboard has priority: no new event starts
// while kbd_pressed is high.
// Ports:
//   clk, nreset  : clock, asynchronous active-low reset
//   ev           : event handshake (slave side)
//   abort        : flush queue and release injected keys
//   kbd_pressed  : physical keyboard has a key down
//   A            : Z80 address bus, A[15:8] active-low row select
//   key_row      : active-low 5-bit overlay for the selected rows (combinational)
//   busy         : sequencer active or queue non-empty
//   err          : one-clock pulse when a popped event had column > 4
module zx_key_autotyper #(
    parameter int unsigned HOLD_CYCLES = 175000,
    parameter int unsigned GAP_CYCLES  = 175000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                nreset,
    zx_key_autotyper_if.slave   ev,
    input  logic                abort,
    input  logic                kbd_pressed,
    input  logic [15:0]         A,
    output logic [4:0]          key_row,
    output logic                busy,
    output logic                err
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0][4:0]   inj_q, inj_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q, wr_vis_q;
    logic [PW-1:0]     fill_c;
    logic              full_c, empty_c, avail_c, push_c, pop_c;
    logic [7:0]        head_c;
    logic [2:0]        head_row_c, head_col_c;

    // Low address byte is not part of the keyboard decode.
    logic              unused_addr_c;
    assign unused_addr_c = ^A[7:0];

    // Queue status; the pop side sees a write one clock after it lands.
    assign fill_c      = wr_ptr_q - rd_ptr_q;
    assign full_c      = (fill_c == PW'(FIFO_DEPTH));
    assign empty_c     = (wr_ptr_q == rd_ptr_q);
    assign avail_c     = (wr_vis_q != rd_ptr_q);
    assign ev.ev_ready = !full_c && !abort;
    assign push_c      = ev.ev_valid && ev.ev_ready;

    assign head_c     = mem_q[rd_ptr_q[AW-1:0]];
    assign head_row_c = head_c[2:0];
    assign head_col_c = head_c[5:3];

    // Queue storage; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ev.ev_data;
        end
    end

    // Queue pointers; abort flushes everything.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_vis_q <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            wr_vis_q <= wr_ptr_q;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inj_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inj_q   <= inj_d;
            err_q   <= err_d;
        end
    end

    // Sequencer next-state: pop/press in IDLE, timed hold and gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inj_d   = inj_q;
        err_d   = 1'b0;
        pop_c   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            inj_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (avail_c && !kbd_pressed) begin
                        pop_c = 1'b1;
                        if (head_col_c > 3'd4) begin
                            err_d = 1'b1;
                        end else begin
                            inj_d = '0;
                            inj_d[head_row_c][head_col_c] = 1'b1;
                            if (head_c[6]) inj_d[0][0] = 1'b1;
                            if (head_c[7]) inj_d[7][1] = 1'b1;
                            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                            state_d = ST_PRESS;
                        end
                    end
                end
                ST_PRESS: begin
                    if (cnt_q == '0) begin
                        inj_d   = '0;
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    inj_d   = '0;
                end
            endcase
        end
    end

    // Row overlay: AND of every selected row's injected keys (pressed = 0).
    always_comb begin
        key_row = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!A[8 + r]) begin
                key_row = key_row & ~inj_q[r];
            end
        end
    end

    assign busy = (state_q != ST_IDLE) || !empty_c;
    assign err  = err_q;

endmodule

// File: tb/tb_zx_key_autotyper.sv
module tb_zx_key_autotyper;

    logic        clk = 1'b0;
    logic        nreset;
    logic        abort;
    logic        kbd_pressed;
    logic [15:0] A;
    logic [4:0]  key_row;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    zx_key_autotyper_if ev_if ();

    zx_key_autotyper #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .ev          (ev_if),
        .abort       (abort),
        .kbd_pressed (kbd_pressed),
        .A           (A),
        .key_row     (key_row),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Press-start monitor: records pattern and cycle of each new press.
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic       seen_not_ready = 1'b0;
    logic [4:0] prev_kr = 5'b11111;
    logic [4:0] mon_pat [$];
    int         mon_cyc [$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en && prev_kr == 5'b11111 && key_row != 5'b11111) begin
            mon_pat.push_back(key_row);
            mon_cyc.push_back(cyc);
        end
        if (mon_en && !ev_if.ev_ready) seen_not_ready = 1'b1;
        prev_kr = key_row;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, input string nm);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < limit) begin
            step();
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s timeout: busy=%b required 0 within %0d cycles", nm, busy, limit);
        end
        step();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        abort = 1'b0;
        kbd_pressed = 1'b0;
        A = 16'h0000;
        ev_if.ev_valid = 1'b0;
        ev_if.ev_data = 8'h00;
        #12;
        n_vec++;
        if (key_row !== 5'b11111) begin n_err++; $display("FAIL reset_key_row got=%b exp=11111", key_row); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err); end
        n_vec++;
        if (ev_if.ev_ready !== 1'b1) begin n_err++; $display("FAIL reset_ev_ready got=%b exp=1", ev_if.ev_ready); end
        nreset = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        A = 16'hFDFE;
        ev_if.ev_data = 8'h01;
        ev_if.ev_valid = 1'b1;
        step();                                  // edge 0
        ev_if.ev_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy_start got=%b exp=1", busy); end
        n_vec++;
        if (key_row !== 5'b11111) begin n_err++; $display("FAIL t1_edge0 key_row got=%b exp=11111", key_row); end
        step();                                  // edge 1
        n_vec++;
        if (key_row !== 5'b11111) begin n_err++; $display("FAIL t1_edge1 key_row got=%b exp=11111", key_row); end
        for (int e = 2; e <= 5; e++) begin
            step();
            n_vec++;
            if (key_row !== 5'b11110) begin n_err++; $display("FAIL t1_press edge%0d key_row got=%b exp=11110", e, key_row); end
            if (e == 3) begin
                A = 16'hFBFF;
                #1;
                n_vec++;
                if (key_row !== 5'b11111) begin n_err++; $display("FAIL t1_other_row key_row got=%b exp=11111", key_row); end
                A = 16'hFDFE;
            end
        end
        for (int e = 6; e <= 8; e++) begin
            step();
            n_vec++;
            if (key_row !== 5'b11111 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL t1_gap edge%0d key_row=%b busy=%b exp 11111/1", e, key_row, busy);
            end
        end
        step();                                  // edge 9
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_end got=%b exp=0", busy); end
        step();
    endtask

    task automatic test_shift();
        A = 16'hFEFE;
        ev_if.ev_data = 8'h63;
        ev_if.ev_valid = 1'b1;
        step();
        ev_if.ev_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (key_row !== 5'b11110) begin n_err++; $display("FAIL t2_row0_caps got=%b exp=11110", key_row); end
        A = 16'hF7FE;
        #1;
        n_vec++;
        if (key_row !== 5'b01111) begin n_err++; $display("FAIL t2_row3_key5 got=%b exp=01111", key_row); end
        A = 16'h00FE;
        #1;
        n_vec++;
        if (key_row !== 5'b01110) begin n_err++; $display("FAIL t2_all_rows got=%b exp=01110", key_row); end
        wait_idle(30, "t2_idle");
    endtask

    task automatic test_back_to_back();
        logic [7:0] evs [6];
        logic [4:0] exp_pat [6];
        int k;
        evs = '{8'h01, 8'h0A, 8'h13, 8'h1C, 8'h25, 8'h66};
        exp_pat = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b01110};
        A = 16'h0000;
        mon_pat.delete();
        mon_cyc.delete();
        seen_not_ready = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ev_if.ev_data = evs[i];
            ev_if.ev_valid = 1'b1;
            k = 0;
            while (!ev_if.ev_ready && k < 50) begin
                step();
                k++;
            end
            step();
        end
        ev_if.ev_valid = 1'b0;
        wait_idle(200, "t3_idle");
        mon_en = 1'b0;
        n_vec++;
        if (seen_not_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready_drop got=%b exp=1", seen_not_ready); end
        n_vec++;
        if (mon_pat.size() != 6) begin
            n_err++;
            $display("FAIL t3_press_count got=%0d exp=6", mon_pat.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (mon_pat[i] !== exp_pat[i]) begin
                    n_err++;
                    $display("FAIL t3_order ev%0d key_row got=%b exp=%b", i, mon_pat[i], exp_pat[i]);
                end
                if (i > 0) begin
                    n_vec++;
                    if (mon_cyc[i] - mon_cyc[i-1] != 8) begin
                        n_err++;
                        $display("FAIL t3_spacing ev%0d got=%0d exp=8", i, mon_cyc[i] - mon_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_kbd_yield();
        A = 16'h0000;
        kbd_pressed = 1'b1;
        ev_if.ev_data = 8'h01;
        ev_if.ev_valid = 1'b1;
        step();
        ev_if.ev_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (key_row !== 5'b11111 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL t4_yield cyc%0d key_row=%b busy=%b exp 11111/1", i, key_row, busy);
            end
        end
        kbd_pressed = 1'b0;
        step();
        n_vec++;
        if (key_row !== 5'b11110) begin n_err++; $display("FAIL t4_release_press got=%b exp=11110", key_row); end
        wait_idle(30, "t4_idle");
    endtask

    task automatic test_abort();
        A = 16'h0000;
        ev_if.ev_valid = 1'b1;
        ev_if.ev_data = 8'h01;
        step();                                  // edge 0
        ev_if.ev_data = 8'h0A;
        step();                                  // edge 1
        ev_if.ev_data = 8'h13;
        step();                                  // edge 2: first event pressed
        ev_if.ev_valid = 1'b0;
        step();
        n_vec++;
        if (key_row !== 5'b11110) begin n_err++; $display("FAIL t5_pressed got=%b exp=11110", key_row); end
        abort = 1'b1;
        ev_if.ev_data = 8'h1C;
        ev_if.ev_valid = 1'b1;
        #1;
        n_vec++;
        if (ev_if.ev_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready_abort got=%b exp=0", ev_if.ev_ready); end
        step();
        abort = 1'b0;
        ev_if.ev_valid = 1'b0;
        n_vec++;
        if (key_row !== 5'b11111) begin n_err++; $display("FAIL t5_released got=%b exp=11111", key_row); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy got=%b exp=0", busy); end
        for (int i = 0; i < 20; i++) begin
            step();
            n_vec++;
            if (key_row !== 5'b11111 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL t5_quiet cyc%0d key_row=%b busy=%b exp 11111/0", i, key_row, busy);
            end
        end
        ev_if.ev_data = 8'h0A;
        ev_if.ev_valid = 1'b1;
        step();
        ev_if.ev_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (key_row !== 5'b11101) begin n_err++; $display("FAIL t5_new_event got=%b exp=11101", key_row); end
        wait_idle(30, "t5_idle");
    endtask

    task automatic test_err();
        A = 16'hFDFE;
        ev_if.ev_data = 8'h28;
        ev_if.ev_valid = 1'b1;
        step();                                  // edge 0
        ev_if.ev_data = 8'h01;
        step();                                  // edge 1
        ev_if.ev_valid = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL t6_err_early got=%b exp=0", err); end
        step();                                  // edge 2: bad event popped
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL t6_err_pulse got=%b exp=1", err); end
        n_vec++;
        if (key_row !== 5'b11111) begin n_err++; $display("FAIL t6_no_press got=%b exp=11111", key_row); end
        step();                                  // edge 3: 'A' pressed
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL t6_err_one_clock got=%b exp=0", err); end
        n_vec++;
        if (key_row !== 5'b11110) begin n_err++; $display("FAIL t6_next_press got=%b exp=11110", key_row); end
        wait_idle(30, "t6_idle");
    endtask

    task automatic test_reset_mid_press();
        A = 16'h0000;
        ev_if.ev_data = 8'h01;
        ev_if.ev_valid = 1'b1;
        step();
        ev_if.ev_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (key_row !== 5'b11110) begin n_err++; $display("FAIL t7_pressed got=%b exp=11110", key_row); end
        nreset = 1'b0;
        #1;
        n_vec++;
        if (key_row !== 5'b11111 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t7_async_reset key_row=%b busy=%b exp 11111/0", key_row, busy);
        end
        step();
        nreset = 1'b1;
        step();
        n_vec++;
        if (key_row !== 5'b11111 || busy !== 1'b0 || ev_if.ev_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t7_after_reset key_row=%b busy=%b ready=%b exp 11111/0/1", key_row, busy, ev_if.ev_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_back_to_back();
        test_kbd_yield();
        test_abort();
        test_err();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
